// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and its serializer.
package uart_pkg;

  // Arbiter FSM states; TAG is only reachable when UART_ARB_TAG_EN is defined.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam logic       UART_START_BIT  = 1'b0;
  localparam logic       UART_STOP_BIT   = 1'b1;
  localparam logic [7:0] UART_TAG_BASE   = 8'hA0;
  localparam int         UART_FRAME_BITS = 10;

  // Cycles per bit, truncating integer division of clock rate by line rate.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_ser.sv
// 8N1 serializer: start bit, eight data bits LSB first, stop bit, each DIV cycles.
// Handshake: a byte moves when in_valid & in_ready are both high on a rising edge;
// in_ready is high only while no frame is on the line.
module uart_tx_ser
  import uart_pkg::*;
#(
  parameter int DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       txd
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic          active;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;

  assign in_ready = ~active;

  // Frame sequencer: start bit driven the cycle after accept, bits advance every DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      txd      <= UART_STOP_BIT;
    end else if (!active) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      if (in_valid) begin
        active <= 1'b1;
        shreg  <= in_data;
        txd    <= UART_START_BIT;
      end else begin
        txd <= UART_STOP_BIT;
      end
    end else if (baud_cnt == CW'(DIV - 1)) begin
      baud_cnt <= '0;
      if (bit_cnt == 4'(UART_FRAME_BITS - 1)) begin
        // Stop bit has run its full length; line stays high.
        active  <= 1'b0;
        bit_cnt <= '0;
        txd     <= UART_STOP_BIT;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == 4'(UART_FRAME_BITS - 2)) begin
          txd <= UART_STOP_BIT;
        end else begin
          txd   <= shreg[0];
          shreg <= {1'b0, shreg[7:1]};
        end
      end
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmit line among NREQ requesters.
// Optional feature macro: UART_ARB_TAG_EN -- when defined, each grant first sends the tag
// byte 8'hA0 | owner_index before the owner's data bytes.
// Handshake: requester i's byte is taken on a rising edge where req_valid[i] & req_ready[i];
// req_ready[i] is only high for the granted owner while the serializer is idle.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic              fpga_sysclk,
  input  logic              rst_fpga_,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              uart_txd,
  output arb_state_t        arb_state
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int IW  = $clog2(NREQ);

  arb_state_t      state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   rr_ptr;
  logic [7:0]      req_bytes [NREQ];
  logic            scan_hit;
  logic [IW-1:0]   scan_idx;
  logic            ser_valid;
  logic            ser_ready;
  logic [7:0]      ser_data;
  logic            accept_last;

  assign arb_state = state;

  // Split the flat data bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_bytes[i] = req_data[8*i +: 8];
    end
  end

  // Round-robin scan: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int j;
    j        = 0;
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!scan_hit && req_valid[j]) begin
        scan_hit = 1'b1;
        scan_idx = IW'(j);
      end
    end
  end

  // Serializer feed: owner's byte in DATA, the tag byte in TAG.
  always_comb begin
    ser_valid = 1'b0;
    ser_data  = req_bytes[owner];
    case (state)
      DATA: ser_valid = req_valid[owner];
`ifdef UART_ARB_TAG_EN
      TAG: begin
        ser_valid = 1'b1;
        ser_data  = UART_TAG_BASE | 8'(owner);
      end
`endif
      default: ser_valid = 1'b0;
    endcase
  end

  assign req_ready   = (state == DATA && ser_ready) ? grant : '0;
  assign accept_last = (state == DATA) && ser_ready && req_valid[owner] && req_last[owner];
  assign busy        = (state != IDLE) | ~ser_ready;

  // Arbitration FSM: grant on scan hit, hold until the owner's last byte is accepted.
  always_ff @(posedge fpga_sysclk or negedge rst_fpga_) begin
    if (!rst_fpga_) begin
      state  <= IDLE;
      grant  <= '0;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_hit) begin
            owner <= scan_idx;
            grant <= {{(NREQ-1){1'b0}}, 1'b1} << scan_idx;
`ifdef UART_ARB_TAG_EN
            state <= TAG;
`else
            state <= DATA;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        TAG: begin
          if (ser_ready) state <= DATA;
        end
`endif
        DATA: begin
          if (accept_last) begin
            rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
            grant  <= '0;
            state  <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  uart_tx_ser #(.DIV(DIV)) u_ser (
    .clk      (fpga_sysclk),
    .rst_n    (rst_fpga_),
    .in_valid (ser_valid),
    .in_data  (ser_data),
    .in_ready (ser_ready),
    .txd      (uart_txd)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-cycle comparison against a transaction-level model,
// a line receiver checking decoded bytes against an expected queue, and literal checks.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NREQ   = 4;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = 10;
  localparam int FRAME  = 10 * DIV;
`ifdef UART_ARB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  typedef struct {
    int         gap;
    logic       last;
    logic [7:0] data;
  } ent_t;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst_fpga_;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              uart_txd;
  arb_state_t        arb_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter #(.NREQ(NREQ), .CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .fpga_sysclk (clk),
    .rst_fpga_   (rst_fpga_),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .busy        (busy),
    .uart_txd    (uart_txd),
    .arb_state   (arb_state)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  ent_t            src_q [NREQ][$];
  logic [NREQ-1:0] fire;
  logic [NREQ-1:0] loaded;
  int              gap_left [NREQ];

  task automatic push(input int r, input logic [7:0] d, input logic l, input int g);
    ent_t e;
    e.gap  = g;
    e.last = l;
    e.data = d;
    src_q[r].push_back(e);
  endtask

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++)
      if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    loaded    = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        ent_t e;
        if (!rst_fpga_) begin
          src_q[i].delete();
          loaded[i]    = 1'b0;
          req_valid[i] = 1'b0;
        end else begin
          if (fire[i] && loaded[i]) begin
            void'(src_q[i].pop_front());
            loaded[i] = 1'b0;
          end
          if (!loaded[i] && src_q[i].size() > 0) begin
            loaded[i]   = 1'b1;
            e           = src_q[i][0];
            gap_left[i] = e.gap;
          end
          if (loaded[i] && gap_left[i] > 0) begin
            gap_left[i]--;
            req_valid[i] = 1'b0;
          end else if (loaded[i]) begin
            e                  = src_q[i][0];
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = e.data;
            req_last[i]        = e.last;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- model, scoreboard and compare process ----------------
  logic [7:0] exp_q [$];
  logic [7:0] rx_log [$];
  int         gnt_log [$];

  int         m_owner = -1;
  int         m_rr    = 0;
  int         m_left  = 0;
  bit         m_tag   = 1'b0;
  logic [9:0] m_frame = '1;
  logic [NREQ-1:0] prev_grant = '0;
  bit         rx_active = 1'b0;
  int         rx_t = 0;
  logic [7:0] rx_byte = '0;

  task automatic start_frame(input logic [7:0] b);
    m_frame = {1'b1, b, 1'b0};
    m_left  = FRAME;
    exp_q.push_back(b);
  endtask

  initial begin
    fire = '0;
    forever begin
      @(negedge clk);
      if (!rst_fpga_) begin
        m_owner = -1; m_rr = 0; m_left = 0; m_tag = 1'b0;
        exp_q.delete();
        fire = '0; rx_active = 1'b0; prev_grant = '0;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_txd", 32'(uart_txd), 1);
      end else begin
        logic [NREQ-1:0] e_grant, e_ready;
        logic            e_txd, e_busy;
        arb_state_t      e_state;
        bit              idle_now, found;
        int              j, pos;
        idle_now = (m_left == 0);
        e_grant  = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
        e_ready  = (m_owner >= 0 && !m_tag && idle_now) ? e_grant : '0;
        e_busy   = (m_owner >= 0) || !idle_now;
        pos      = (FRAME - m_left) / DIV;
        e_txd    = idle_now ? 1'b1 : m_frame[pos];
        e_state  = (m_owner < 0) ? IDLE : (m_tag ? TAG : DATA);
        chk("grant", 32'(grant), 32'(e_grant));
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("uart_txd", 32'(uart_txd), 32'(e_txd));
        chk("arb_state", 32'(arb_state), 32'(e_state));

        if (grant != 0 && prev_grant == 0)
          for (int i = 0; i < NREQ; i++) if (grant[i]) gnt_log.push_back(i);
        prev_grant = grant;
        fire = req_valid & req_ready;

        // Line receiver: samples mid-bit from the first low cycle.
        if (!rx_active && uart_txd == 1'b0) begin
          rx_active = 1'b1;
          rx_t      = 0;
        end
        if (rx_active) begin
          if (rx_t % DIV == DIV / 2) begin
            int k;
            k = rx_t / DIV;
            if (k == 0) chk("rx_start", 32'(uart_txd), 0);
            else if (k <= 8) rx_byte[k-1] = uart_txd;
            else begin
              chk("rx_stop", 32'(uart_txd), 1);
              rx_log.push_back(rx_byte);
              if (exp_q.size() == 0) chk("rx_unexpected", 32'(rx_byte), 32'h100);
              else chk("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
              rx_active = 1'b0;
            end
          end
          rx_t++;
        end

        // Advance the model by one clock.
        if (m_left > 0) m_left--;
        if (m_owner < 0) begin
          found = 1'b0;
          for (int k = 0; k < NREQ; k++) begin
            j = (m_rr + k) % NREQ;
            if (!found && req_valid[j]) begin
              found   = 1'b1;
              m_owner = j;
              m_tag   = TAG_EN;
            end
          end
        end else if (m_tag) begin
          if (idle_now) begin
            start_frame(8'hA0 | 8'(m_owner));
            m_tag = 1'b0;
          end
        end else if (idle_now && req_valid[m_owner]) begin
          start_frame(req_data[8*m_owner +: 8]);
          if (req_last[m_owner]) begin
            m_rr    = (m_owner + 1) % NREQ;
            m_owner = -1;
          end
        end
      end
    end
  end

  // ---------------- helper tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_fpga_ = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_fpga_ = 1'b1;
    repeat (2) @(negedge clk);
    gnt_log.delete();
    rx_log.delete();
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    @(negedge clk);
    while (c < 20000 && (pending() || busy || rx_active || loaded != 0)) begin
      @(negedge clk);
      c++;
    end
    chk(name, 32'(c < 20000), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_fire(input int r, output int t);
    t = -1;
    for (int c = 0; c < 2000 && t < 0; c++) begin
      @(negedge clk);
      if (req_valid[r] && req_ready[r]) t = cyc;
    end
    chk("fire_seen", 32'(t >= 0), 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [9:0] pat;
    int         t, rdy_cnt, viol, k;
    rst_fpga_ = 1'b1;
    #1 rst_fpga_ = 1'b0;
    repeat (3) @(negedge clk);
    chk("t0_txd", 32'(uart_txd), 1);
    chk("t0_grant", 32'(grant), 0);
    chk("t0_state", 32'(arb_state), 32'(IDLE));
    #2 rst_fpga_ = 1'b1;
    repeat (2) @(negedge clk);

    // T1: single byte 0x55 from requester 0.
    pat = 10'h2AA;
    push(0, 8'h55, 1'b1, 0);
    rdy_cnt = 0; t = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (req_ready[0]) rdy_cnt++;
      if (t < 0 && req_valid[0] && req_ready[0]) t = cyc;
      if (t >= 0) begin
        k = cyc - t;
        if (k >= 6 && (k - 6) % DIV == 0 && (k - 6) / DIV < 10 && !TAG_EN)
          chk("t1_bit", 32'(uart_txd), 32'(pat[(k-6)/DIV]));
        if (k == 100) chk("t1_busy_hi", 32'(busy), 1);
        if (k == 101) begin
          chk("t1_busy_lo", 32'(busy), 0);
          chk("t1_grant_lo", 32'(grant), 0);
          break;
        end
      end
    end
    chk("t1_accepted", 32'(t >= 0), 1);
    chk("t1_ready_cycles", 32'(rdy_cnt), 1);
    wait_idle("t1_idle");

    // T2: contention, req0 three bytes vs req2 one byte, then rr_ptr at 3.
    do_reset();
    push(0, 8'h11, 1'b0, 0); push(0, 8'h22, 1'b0, 0); push(0, 8'h33, 1'b1, 0);
    push(2, 8'h44, 1'b1, 0);
    wait_idle("t2_idle");
    chk("t2_grants", 32'(gnt_log.size()), 2);
    chk("t2_g0", 32'(gnt_log[0]), 0);
    chk("t2_g1", 32'(gnt_log[1]), 2);
    if (!TAG_EN) begin
      chk("t2_rx_n", 32'(rx_log.size()), 4);
      chk("t2_rx0", 32'(rx_log[0]), 32'h11);
      chk("t2_rx2", 32'(rx_log[2]), 32'h33);
      chk("t2_rx3", 32'(rx_log[3]), 32'h44);
    end
    push(0, 8'h55, 1'b1, 0);
    push(3, 8'h66, 1'b1, 0);
    wait_idle("t2b_idle");
    chk("t2_g2_rr3", 32'(gnt_log[2]), 3);
    chk("t2_g3", 32'(gnt_log[3]), 0);

    // T3: fairness with all four requesters holding single-byte packets.
    do_reset();
    for (int r = 0; r < NREQ; r++) begin
      push(r, 8'($urandom_range(0, 255)), 1'b1, 0);
      push(r, 8'($urandom_range(0, 255)), 1'b1, 0);
    end
    wait_idle("t3_idle");
    chk("t3_grants", 32'(gnt_log.size()), 8);
    for (int i = 0; i < 6; i++) chk("t3_order", 32'(gnt_log[i]), 32'(i % NREQ));

    // T4: owner 1 stalls mid-packet for 500 cycles while req3 waits.
    do_reset();
    push(1, 8'hC3, 1'b0, 0);
    push(1, 8'h5A, 1'b1, 500);
    push(3, 8'h96, 1'b1, 0);
    wait_fire(1, t);
    repeat (150) @(negedge clk);
    viol = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (grant != 4'b0010 || req_ready[3] || !uart_txd) viol++;
    end
    chk("t4_stall_viol", 32'(viol), 0);
    wait_idle("t4_idle");
    chk("t4_g0", 32'(gnt_log[0]), 1);
    chk("t4_g1", 32'(gnt_log[1]), 3);

    // T5: reset during data bit 4 of a 0x00 byte from req2.
    do_reset();
    push(2, 8'h00, 1'b1, 0);
    wait_fire(2, t);
    repeat (54) @(negedge clk);
    chk("t5_bit4_low", 32'(uart_txd), 0);
    #2 rst_fpga_ = 1'b0;
    #1;
    chk("t5_async_txd", 32'(uart_txd), 1);
    chk("t5_async_grant", 32'(grant), 0);
    chk("t5_async_busy", 32'(busy), 0);
    do_reset();
    push(1, 8'h77, 1'b1, 0);
    push(3, 8'h88, 1'b1, 0);
    wait_idle("t5_idle");
    chk("t5_first_winner", 32'(gnt_log[0]), 1);

`ifdef UART_ARB_TAG_EN
    // T6: tag byte precedes data.
    do_reset();
    push(1, 8'h3C, 1'b1, 0);
    wait_idle("t6_idle");
    chk("t6_rx_n", 32'(rx_log.size()), 2);
    chk("t6_tag", 32'(rx_log[0]), 32'hA1);
    chk("t6_data", 32'(rx_log[1]), 32'h3C);
`endif

    // Randomized rounds of packets with random gaps.
    do_reset();
    for (int round = 0; round < 6; round++) begin
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(0, 3) != 0) begin
          int n;
          n = $urandom_range(1, 3);
          for (int b = 0; b < n; b++)
            push(r, 8'($urandom_range(0, 255)), 1'(b == n - 1), $urandom_range(0, 20));
        end
      end
      wait_idle("rand_idle");
    end

    chk("exp_q_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: the sequence above needs well under 2 ms.
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
